alu181_word_seq: RTL

Multi-cycle sequencer that performs 4·NIBBLES-bit arithmetic/logic operations by driving a single `alu74181` slice one nibble per clock, LSB first, rippling the active-low carry through a register. It sits directly upstream of the `alu74181` slice, which it instantiates as its sub-module. It feeds the slice its S/M/A/B/CNb inputs and consumes F/CN4b/AEB to assemble a full-width result. Operands and results are exchanged over valid/ready handshakes.

---
 rtl/alu181_pkg.sv | 18 +
 rtl/alu74181.sv | 49 ++++
 rtl/alu181_word_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu181_pkg.sv
// Shared types and constants for the nibble-serial 74181 word sequencer.
package alu181_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Common function selects; the comment gives the mode bit each one needs.
  localparam logic [3:0] S_ADD = 4'b1001;  // M=0
  localparam logic [3:0] S_SUB = 4'b0110;  // M=0
  localparam logic [3:0] S_XOR = 4'b0110;  // M=1
  localparam logic [3:0] S_AND = 4'b1011;  // M=1

endpackage

// File: rtl/alu74181.sv
// One 4-bit 74181 ALU slice, active-high data, active-low carry in/out.
module alu74181 (
  input  logic [3:0] s,
  input  logic       m,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cnb,
  output logic [3:0] f,
  output logic       cn4b,
  output logic       aeb,
  output logic       x,
  output logic       y
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c0;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  // Per-bit propagate/generate terms selected by S; g always implies p.
  always_comb begin
    p = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    g = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
  end

  // Lookahead carries, written out per bit so each stage is its own net.
  always_comb begin
    c0 = ~cnb;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
  end

  // Logic mode forces every internal carry high, which turns the sum into XNOR of p and g.
  always_comb begin
    f = (p ^ g) ^ ({4{m}} | {c3, c2, c1, c0});
  end

  assign cn4b = ~c4;
  assign aeb  = &f;
  assign x    = ~(&p);
  assign y    = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));

endmodule

// File: rtl/alu181_word_seq.sv
// Word-wide ALU built by stepping a single 74181 slice across the operands, LSB nibble first.
module alu181_word_seq
  import alu181_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  in_s,
  input  logic                        in_m,
  input  logic                        in_cnb,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_f,
  output logic                        out_cn4b,
  output logic                        out_aeb,
  output logic                        busy
);

  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t state;
  state_t state_next;

  logic [3:0]                         s_reg;
  logic                               m_reg;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_reg;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_reg;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   res;
  logic                               carry_n;
  logic                               aeb_acc;
  logic [CNT_W-1:0]                   cnt;
  logic                               last;

  logic [NIBBLE_W-1:0] slice_f;
  logic                slice_cn4b;
  logic                slice_aeb;
  logic                slice_x_unused;
  logic                slice_y_unused;

  assign last = (cnt == CNT_W'(NIBBLES - 1));

  alu74181 u_slice (
    .s    (s_reg),
    .m    (m_reg),
    .a    (a_reg[cnt]),
    .b    (b_reg[cnt]),
    .cnb  (carry_n),
    .f    (slice_f),
    .cn4b (slice_cn4b),
    .aeb  (slice_aeb),
    .x    (slice_x_unused),
    .y    (slice_y_unused)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; nothing is accepted outside IDLE.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on accept, then one nibble per clock with the carry rippling through carry_n.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg   <= '0;
      m_reg   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      res     <= '0;
      carry_n <= 1'b1;
      aeb_acc <= 1'b0;
      cnt     <= '0;
    end else if (state == IDLE && in_valid) begin
      s_reg   <= in_s;
      m_reg   <= in_m;
      a_reg   <= in_a;
      b_reg   <= in_b;
      carry_n <= in_cnb;
      aeb_acc <= 1'b1;
      cnt     <= '0;
    end else if (state == RUN) begin
      res[cnt] <= slice_f;
      carry_n  <= slice_cn4b;
      aeb_acc  <= aeb_acc & slice_aeb;
      if (!last) cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_f    = res;
  assign out_cn4b = carry_n;
  assign out_aeb  = aeb_acc;

endmodule
